mux_tree_cfg_bank: RTL and testbench
====================================

# mux_tree_cfg_bank

Parametrised bank of `NUM_OUT` routing mux trees with an integrated configuration chain. All trees select from one shared `NUM_IN`-wide input bus, and unused tree leaves are tied to constant 1. Select bits load serially through a `ccff_head`→`ccff_tail` shadow chain and are double-buffered: they reach the datapath only on a checked `commit`. The block replaces fixed-size, externally-configured routing muxes in connection/switch blocks, and adds load counting, commit validation and an error flag.

## Interface
Parameters:
- `NUM_IN`, default 18: number of data inputs per tree; minimum 2.
- `NUM_OUT`, default 1: number of independent mux trees.
- `SEL_W` (localparam), equal to `$clog2(NUM_IN+1)`: select bits per tree. At least one leaf is always constant 1.
- `CHAIN_LEN` (localparam), equal to `NUM_OUT*SEL_W`: configuration chain length.

Ports:
- `prog_clk`, input, 1: the single clock.
- `prog_reset`, input, 1: reset, synchronous and active-high.
- `ccff_head`, input, 1: serial configuration data in.
- `shift_en`, input, 1: shift the chain by one bit this cycle.
- `commit`, input, 1: request copy of the shadow chain to the active selects.
- `in`, input, `NUM_IN`: shared data inputs.
- `out`, output, `NUM_OUT`: mux outputs.
- `ccff_tail`, output, 1: serial configuration data out; this is the last shadow flop.
- `cfg_loaded`, output, 1: high when exactly `CHAIN_LEN` bits have been shifted since the last reset or accepted commit.
- `cfg_err`, output, 1: sticky configuration-protocol error.

## Operation
Shadow chain:
- `shadow[CHAIN_LEN-1:0]`.
- On `shift_en`: `shadow <= {shadow[CHAIN_LEN-2:0], ccff_head}`.
- `ccff_tail = shadow[CHAIN_LEN-1]`.
- The first bit shifted in ends up in the MSB.

Select mapping:
- Tree m uses `active[m*SEL_W +: SEL_W]`.
- Bit j of that slice is tree-level j+1 select. Level 1 is nearest the leaves; a select value of 1 picks the A1 (lower-index) branch.
- Resulting behaviour: `code = active slice` (unsigned); `idx = 2^SEL_W-1-code`.
- `out[m] = (idx < NUM_IN) ? in[idx] : 1'b1`.

Bit counter `cnt`:
- Width is `$clog2(CHAIN_LEN+2)`.
- Increments on each `shift_en` and saturates at `CHAIN_LEN+1`, which marks an over-shift.
- `cfg_loaded = (cnt == CHAIN_LEN)`.

Commit, evaluated each cycle using pre-edge values:
- Accepted when `commit && cfg_loaded && !shift_en`. Then `active <= shadow` and `cnt <= 0`.
- Rejected when `commit` is high and the accept condition is false. Then `active` is unchanged and `cfg_err <= 1`. Any `shift_en` in the same cycle still shifts and counts, and `cnt` is not cleared.
- `cfg_err` is cleared only by `prog_reset`.

Reset, which has priority over everything:
- `shadow`, `active`, `cnt` and `cfg_err` go to 0.
- Hence `code` is 0 for every tree and `out` is all ones; `ccff_tail` is 0 and `cfg_loaded` is 0.

## Timing
- Serial load takes `CHAIN_LEN` shift cycles. `cfg_loaded` asserts in the cycle after the last shift.
- An accepted commit updates `active` at the clock edge. With the macro undefined, `out` reflects the new selection combinationally in the following cycle.
- The datapath path from `in` to `out` is purely combinational with the macro undefined.
- `ccff_tail` reproduces `ccff_head` delayed by `CHAIN_LEN` shifting cycles. Cycles without `shift_en` hold the chain.
- Reset mid-load discards partial shadow contents at the reset edge.

## Configuration
Macro: `MUX_TREE_CFG_OUT_REG_EN`.
- Defined: `out` is registered on `prog_clk`, adding exactly 1 cycle of latency for both input changes and commits. The output register resets to all ones.
- Undefined: `out` is combinational from `in` and `active`, with 0 cycles of latency.

## Test plan
All scenarios use `NUM_IN=6` and `NUM_OUT=2`, giving `SEL_W=3` and `CHAIN_LEN=6`. The macro is undefined unless stated.
- Reset: hold `prog_reset` for 2 cycles with arbitrary `in` → `out=2'b11`, `ccff_tail=0`, `cfg_loaded=0`, `cfg_err=0`.
- Load and select: shift 1,1,0,1,0,1, so `shadow=6'b110101` (tree0 code 5 selects `in[2]`, tree1 code 6 selects `in[1]`) → `cfg_loaded=1`. Commit, then drive `in=6'b000100` → `out=2'b01`. Drive `in=6'b000010` → `out=2'b10`.
- Short commit: after 4 shifts assert `commit` → `cfg_err=1`, `out` unchanged, `cfg_loaded` still 0.
- Over-shift: shift 7 bits → `cfg_loaded` 1 after bit 6, 0 after bit 7. Then commit → rejected, `cfg_err=1`.
- Chain pass-through: shift 12 bits of pattern 101100_011010 → `ccff_tail` emits the first 6 bits in order during shifts 7–12.
- Reset mid-load and registered output: reset after 3 shifts → `cnt=0` and `out=2'b11`. Repeat scenario 2 with `MUX_TREE_CFG_OUT_REG_EN` defined → `out` changes exactly one cycle later.

Source files
------------

// File: rtl/mux_tree_cfg_bank_if.sv
// Bus interface for mux_tree_cfg_bank: configuration chain, commit handshake,
// status flags and the shared datapath. Clock and reset stay outside.
interface mux_tree_cfg_bank_if #(
  parameter int NUM_IN  = 18,
  parameter int NUM_OUT = 1
);
  logic               ccff_head;
  logic               shift_en;
  logic               commit;
  logic [NUM_IN-1:0]  in;
  logic [NUM_OUT-1:0] out;
  logic               ccff_tail;
  logic               cfg_loaded;
  logic               cfg_err;

  modport master (
    output ccff_head, shift_en, commit, in,
    input  out, ccff_tail, cfg_loaded, cfg_err
  );

  modport slave (
    input  ccff_head, shift_en, commit, in,
    output out, ccff_tail, cfg_loaded, cfg_err
  );
endinterface

// File: rtl/mux_tree_cfg_bank.sv
// mux_tree_cfg_bank: NUM_OUT binary mux trees over a shared NUM_IN-wide bus.
// Select bits arrive serially through a shadow chain (ccff_head -> ccff_tail)
// and only reach the trees on a validated commit. Unused leaves are tied to 1.
// Optional feature macro: MUX_TREE_CFG_OUT_REG_EN registers `out` (resets to ones).
module mux_tree_cfg_bank #(
  parameter int NUM_IN  = 18,
  parameter int NUM_OUT = 1
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  mux_tree_cfg_bank_if.slave  bus
);

  localparam int SEL_W     = $clog2(NUM_IN + 1);
  localparam int CHAIN_LEN = NUM_OUT * SEL_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam int LEAVES    = 2 ** SEL_W;
  localparam int PAD_W     = LEAVES - NUM_IN;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] r_shadow;
  logic [CHAIN_LEN-1:0] r_active;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_cfg_err;

  logic                 w_loaded;
  logic                 w_accept;
  logic                 w_reject;
  logic [LEAVES-1:0]    w_leaves;
  logic [NUM_OUT-1:0]   w_out;

  // Walk the tree level by level. At level j+1 a select of 1 keeps the
  // lower-index branch of each pair, so the chosen leaf is ~code.
  function automatic logic f_tree(input logic [LEAVES-1:0] leaves,
                                  input logic [SEL_W-1:0]  sel);
    logic [LEAVES-1:0] lvl;
    lvl = leaves;
    for (int j = 0; j < SEL_W; j++) begin
      for (int k = 0; k < (LEAVES >> (j + 1)); k++) begin
        lvl[k] = sel[j] ? lvl[2*k] : lvl[2*k+1];
      end
    end
    return lvl[0];
  endfunction

  assign w_loaded = (r_cnt == CNT_FULL);
  assign w_accept = bus.commit && w_loaded && !bus.shift_en;
  assign w_reject = bus.commit && !w_accept;
  assign w_leaves = {{PAD_W{1'b1}}, bus.in};

  // Shadow chain: shift in ccff_head at the LSB, first bit ends up at the MSB.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_shadow <= '0;
    end else if (bus.shift_en) begin
      r_shadow <= {r_shadow[CHAIN_LEN-2:0], bus.ccff_head};
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Active selects: copied from the shadow only on an accepted commit.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_active <= '0;
    end else if (w_accept) begin
      r_active <= r_shadow;
    end else begin
      r_active <= r_active;
    end
  end

  // Bit counter: counts shifts, saturates one past full to flag an over-shift.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (bus.shift_en && (r_cnt != CNT_OVER)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Sticky protocol error: any commit that is not accepted sets it.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_cfg_err <= 1'b0;
    end else if (w_reject) begin
      r_cfg_err <= 1'b1;
    end else begin
      r_cfg_err <= r_cfg_err;
    end
  end

  // Datapath: one tree per output, each driven by its own slice of the selects.
  always_comb begin
    w_out = '1;
    for (int m = 0; m < NUM_OUT; m++) begin
      w_out[m] = f_tree(w_leaves, r_active[m*SEL_W +: SEL_W]);
    end
  end

`ifdef MUX_TREE_CFG_OUT_REG_EN
  logic [NUM_OUT-1:0] r_out;

  // Optional output register: one cycle of latency for both in and commits.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_out <= '1;
    end else begin
      r_out <= w_out;
    end
  end

  assign bus.out = r_out;
`else
  assign bus.out = w_out;
`endif

  assign bus.ccff_tail  = r_shadow[CHAIN_LEN-1];
  assign bus.cfg_loaded = w_loaded;
  assign bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_mux_tree_cfg_bank.sv
// Self-checking bench for mux_tree_cfg_bank with NUM_IN=6, NUM_OUT=2
// (SEL_W=3, CHAIN_LEN=6). Table-driven datapath vectors plus directed
// sequences for the configuration-protocol corner cases.
module tb_mux_tree_cfg_bank;

  logic prog_clk;
  logic prog_reset;
  int   n_cmp;
  int   n_err;

  mux_tree_cfg_bank_if #(.NUM_IN(6), .NUM_OUT(2)) bus ();

  mux_tree_cfg_bank #(.NUM_IN(6), .NUM_OUT(2)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .bus        (bus)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [5:0] cfg;
    logic [5:0] in;
    logic [1:0] exp_out;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    prog_reset   = 1'b1;
    bus.shift_en = 1'b0;
    bus.commit   = 1'b0;
    repeat (n) tick();
    prog_reset   = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    bus.ccff_head = b;
    bus.shift_en  = 1'b1;
    tick();
    bus.shift_en  = 1'b0;
  endtask

  task automatic load_cfg(input logic [5:0] cfg);
    for (int i = 5; i >= 0; i--) shift_bit(cfg[i]);
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  // Let the output settle after an input or commit change.
  task automatic settle();
`ifdef MUX_TREE_CFG_OUT_REG_EN
    tick();
`else
    #1;
`endif
  endtask

  logic [5:0]  cur_cfg;
  logic [11:0] pat;

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    prog_reset    = 1'b1;
    bus.ccff_head = 1'b0;
    bus.shift_en  = 1'b0;
    bus.commit    = 1'b0;
    bus.in        = 6'b101010;

    // cfg 110101: tree0 code 5 -> in[2], tree1 code 6 -> in[1]
    vecs[0]  = '{6'b110101, 6'b000100, 2'b01};
    vecs[1]  = '{6'b110101, 6'b000010, 2'b10};
    vecs[2]  = '{6'b110101, 6'b000110, 2'b11};
    vecs[3]  = '{6'b110101, 6'b111001, 2'b00};
    vecs[4]  = '{6'b110101, 6'b000000, 2'b00};
    // cfg 010111: tree0 code 7 -> in[0], tree1 code 2 -> in[5]
    vecs[5]  = '{6'b010111, 6'b000001, 2'b01};
    vecs[6]  = '{6'b010111, 6'b100000, 2'b10};
    vecs[7]  = '{6'b010111, 6'b011110, 2'b00};
    vecs[8]  = '{6'b010111, 6'b100001, 2'b11};
    // cfg 001000: tree1 code 1 -> leaf 6, tree0 code 0 -> leaf 7, both constant 1
    vecs[9]  = '{6'b001000, 6'b000000, 2'b11};
    vecs[10] = '{6'b001000, 6'b111111, 2'b11};
    vecs[11] = '{6'b001000, 6'b010101, 2'b11};

    // Reset state
    do_reset(2);
    check("rst_out",    32'(bus.out),        32'h3);
    check("rst_tail",   32'(bus.ccff_tail),  32'h0);
    check("rst_loaded", 32'(bus.cfg_loaded), 32'h0);
    check("rst_err",    32'(bus.cfg_err),    32'h0);

    // Table-driven load/commit/select
    cur_cfg = 6'b000000;
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].cfg != cur_cfg) begin
        for (int i = 5; i >= 0; i--) begin
          check("load_pre", 32'(bus.cfg_loaded), 32'h0);
          shift_bit(vecs[v].cfg[i]);
        end
        check("load_done", 32'(bus.cfg_loaded), 32'h1);
        check("load_tail", 32'(bus.ccff_tail),  32'(vecs[v].cfg[5]));
        do_commit();
        check("commit_loaded", 32'(bus.cfg_loaded), 32'h0);
        check("commit_err",    32'(bus.cfg_err),    32'h0);
        cur_cfg = vecs[v].cfg;
      end
      bus.in = vecs[v].in;
      settle();
      check($sformatf("vec%0d_out", v), 32'(bus.out), 32'(vecs[v].exp_out));
    end

    // Short commit after 4 shifts, then shift+commit in one cycle
    do_reset(1);
    load_cfg(6'b110101);
    do_commit();
    bus.in = 6'b000100;
    settle();
    check("short_pre_out", 32'(bus.out), 32'h1);
    for (int i = 0; i < 4; i++) shift_bit(1'b0);
    do_commit();
    check("short_err",    32'(bus.cfg_err),    32'h1);
    check("short_loaded", 32'(bus.cfg_loaded), 32'h0);
    settle();
    check("short_out",    32'(bus.out),        32'h1);
    shift_bit(1'b0);
    shift_bit(1'b0);
    check("short_cnt_kept", 32'(bus.cfg_loaded), 32'h1);
    bus.ccff_head = 1'b1;
    bus.shift_en  = 1'b1;
    bus.commit    = 1'b1;
    tick();
    bus.shift_en  = 1'b0;
    bus.commit    = 1'b0;
    check("shcm_loaded", 32'(bus.cfg_loaded), 32'h0);
    check("shcm_tail",   32'(bus.ccff_tail),  32'h0);
    settle();
    check("shcm_out",    32'(bus.out),        32'h1);

    // Over-shift: 7 bits, then commit rejected
    do_reset(1);
    check("over_err_clr", 32'(bus.cfg_err), 32'h0);
    for (int i = 0; i < 7; i++) begin
      shift_bit(1'b1);
      if (i == 5) check("over_loaded6", 32'(bus.cfg_loaded), 32'h1);
      if (i == 6) check("over_loaded7", 32'(bus.cfg_loaded), 32'h0);
    end
    do_commit();
    check("over_err", 32'(bus.cfg_err), 32'h1);
    settle();
    check("over_out", 32'(bus.out),     32'h3);

    // Chain pass-through: tail emits first 6 bits during shifts 7..12
    do_reset(1);
    pat = 12'b101100_011010;
    for (int k = 1; k <= 12; k++) begin
      if (k >= 7) check($sformatf("pass_tail%0d", k), 32'(bus.ccff_tail), 32'(pat[18-k]));
      shift_bit(pat[12-k]);
    end
    tick();
    check("pass_hold", 32'(bus.ccff_tail), 32'(pat[5]));

    // Reset mid-load discards partial contents and count
    do_reset(1);
    shift_bit(1'b1);
    shift_bit(1'b1);
    shift_bit(1'b1);
    do_reset(1);
    check("mid_loaded", 32'(bus.cfg_loaded), 32'h0);
    check("mid_tail",   32'(bus.ccff_tail),  32'h0);
    check("mid_out",    32'(bus.out),        32'h3);
    for (int i = 0; i < 6; i++) begin
      shift_bit(1'b0);
      if (i == 4) check("mid_loaded5", 32'(bus.cfg_loaded), 32'h0);
      if (i == 5) check("mid_loaded6", 32'(bus.cfg_loaded), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
